spram_arbiter_4096_60bit: RTL and testbench
===========================================

# spram_arbiter_4096_60bit

Two-requester round-robin arbiter and sequencer for a single-port 4096 x 60-bit RAM (12-bit address, 1-cycle registered read, output held on write cycles). It drives the RAM command port, grants at most one access per cycle, and steers the registered read data back to the requester that issued the read. It optionally zero-fills the whole array after reset before it accepts traffic.

## Interface
- AWIDTH, 12, RAM address width
- NUM_WORDS, 4096, RAM depth; the init sweep covers 0..NUM_WORDS-1
- DWIDTH, 60, RAM data width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- a_req / b_req  in  1  request; held high with command stable until granted
- a_wren / b_wren  in  1  1 = write, 0 = read
- a_addr / b_addr  in  AWIDTH  access address
- a_wdata / b_wdata  in  DWIDTH  write data
- a_gnt / b_gnt  out  1  combinational; access accepted at this clock edge
- a_rvalid / b_rvalid  out  1  registered; read data valid this cycle
- a_rdata / b_rdata  out  DWIDTH  read data (= ram_out); meaningful only while the matching rvalid is high
- ram_address  out  AWIDTH  to the RAM address port
- ram_wren  out  1  to the RAM write enable
- ram_data  out  DWIDTH  to the RAM data port
- ram_out  in  DWIDTH  from the RAM read port
- init_done  out  1  high once the arbiter accepts requests

## Operation
- States: INIT (macro only) and ARB.
- INIT:
  - a 12-bit counter starts at 0;
  - each cycle drives ram_wren=1, ram_address=counter, ram_data=0;
  - after address NUM_WORDS-1 is written, the next state is ARB and init_done rises.
  - a_gnt, b_gnt, a_rvalid and b_rvalid stay 0 throughout INIT.
- ARB:
  - Only A requests: A is granted. Only B requests: B is granted.
  - Both request: the holder of the priority pointer wins.
  - After any grant, the pointer moves to the other requester. The pointer is unchanged in idle cycles.
  - Granted command passes combinationally to ram_address, ram_wren and ram_data.
  - No grant: ram_wren=0, ram_address=0, ram_data=0. This is a harmless read of word 0, and no rvalid is raised for it.
  - A granted read sets a 1-bit owner register and raises the owner's rvalid on the next cycle.
  - A granted write raises no rvalid.
- Ordering: accesses take effect in grant order. A read granted at edge N+1 returns data written by a write granted at edge N or earlier.
- Fairness: with both requests held continuously, grants alternate A, B, A, B, and so on. Neither requester waits more than one cycle.
- Reset at any time, including mid-INIT:
  - priority pointer = A, rvalid = 0, owner = A;
  - init counter returns to 0;
  - state returns to INIT (macro) or ARB (no macro).

## Timing
- Grant: same cycle as the request, combinational from req, pointer and state.
- Read latency: read granted at edge N gives rvalid high and ram_out valid in the cycle after edge N, for exactly one cycle per granted read.
- Back-to-back reads: one rvalid per cycle, in grant order. Owners may interleave A and B.
- Reset values:
  - a_gnt = b_gnt = 0 and a_rvalid = b_rvalid = 0;
  - ram_wren = 0, ram_address = 0, ram_data = 0;
  - init_done = 0 with the macro, 1 without it.
- INIT duration: NUM_WORDS cycles (4096) after reset deasserts. init_done is high from the 4097th edge on.

## Configuration
- SPRAM_ARB_INIT_EN defined:
  - INIT state and the zero-fill counter are built;
  - init_done resets to 0 and rises after 4096 cycles.
- Not defined:
  - no INIT state and no counter;
  - ARB starts from reset and init_done is tied to 1;
  - RAM contents after reset are undefined.

## Test plan
- Zero-fill (macro on): release reset; init_done stays 0 for 4096 cycles with no gnt. Then A reads 0x000, 0x7FF and 0xFFF, and each returns 60'h0 with a_rvalid one cycle after grant.
- Single requester: A writes 60'hABC_DEF0_1234_567 to 0x123, then reads 0x123 the next cycle. a_gnt is high both cycles, and a_rvalid/a_rdata return 60'hABC_DEF0_1234_567 one cycle after the read grant.
- Contention: A and B hold reads to 0x010 and 0x020 continuously for 6 cycles from reset. Grants go A, B, A, B, A, B, and rvalid alternates one cycle later with the correct data per owner.
- Write-then-read across requesters: B writes 60'h5 to 0x040 in the same cycle A reads 0x040. The winner goes first: if A wins, A sees the old value and a later A read returns 60'h5.
- Reset mid-INIT: assert reset at counter 0x800 and release it. The sweep restarts at 0, and init_done rises 4096 cycles after the release.
- Macro off: init_done = 1 immediately after reset, and an A read at the first cycle is granted with a_rvalid on the next cycle.

Source files
------------

// File: rtl/spram_arbiter_4096_60bit_if.sv
// rtl/spram_arbiter_4096_60bit_if.sv - requester A/B, RAM command and read-return bundle
// Ports (signals): a_/b_ req, wren, addr, wdata, gnt, rvalid, rdata;
//   ram_address, ram_wren, ram_data, ram_out; init_done.
// Modports: slave = arbiter side, master = requester/RAM side.
interface spram_arbiter_4096_60bit_if #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 60
);
    logic              a_req;
    logic              a_wren;
    logic [AWIDTH-1:0] a_addr;
    logic [DWIDTH-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DWIDTH-1:0] a_rdata;

    logic              b_req;
    logic              b_wren;
    logic [AWIDTH-1:0] b_addr;
    logic [DWIDTH-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DWIDTH-1:0] b_rdata;

    logic [AWIDTH-1:0] ram_address;
    logic              ram_wren;
    logic [DWIDTH-1:0] ram_data;
    logic [DWIDTH-1:0] ram_out;

    logic              init_done;

    modport slave (
        input  a_req, a_wren, a_addr, a_wdata,
        input  b_req, b_wren, b_addr, b_wdata,
        input  ram_out,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_address, ram_wren, ram_data,
        output init_done
    );

    modport master (
        output a_req, a_wren, a_addr, a_wdata,
        output b_req, b_wren, b_addr, b_wdata,
        output ram_out,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_address, ram_wren, ram_data,
        input  init_done
    );
endinterface

// File: rtl/spram_arbiter_4096_60bit.sv
// rtl/spram_arbiter_4096_60bit.sv - two-requester round-robin arbiter for a 4096 x 60 single-port RAM
// Optional feature macro: SPRAM_ARB_INIT_EN (zero-fill the whole RAM after reset before granting).
// Ports: clk   - rising-edge clock
//        reset - asynchronous active-high reset
//        bus   - slave modport: A/B command + combinational grant, registered read return,
//                RAM command port (address/wren/data) and read port (ram_out), init_done.
module spram_arbiter_4096_60bit #(
    parameter int AWIDTH    = 12,
    parameter int DWIDTH    = 60
`ifdef SPRAM_ARB_INIT_EN
    ,
    parameter int NUM_WORDS = 4096
`endif
) (
    input logic                      clk,
    input logic                      reset,
    spram_arbiter_4096_60bit_if.slave bus
);

    logic prio_b;    // 1: B wins a tie on the next contended cycle
    logic owner_b;   // requester that issued the read now in flight
    logic rd_valid;  // a read was granted at the previous edge
    logic arb_en;
    logic a_win;
    logic b_win;

`ifdef SPRAM_ARB_INIT_EN
    typedef enum logic {ST_INIT, ST_ARB} state_t;
    state_t            state;
    logic [AWIDTH-1:0] init_cnt;

    assign arb_en        = (state == ST_ARB);
    assign bus.init_done = (state == ST_ARB);
`else
    assign arb_en        = 1'b1;
    assign bus.init_done = 1'b1;
`endif

    always_comb begin
        a_win = bus.a_req && (!bus.b_req || !prio_b);
        b_win = bus.b_req && (!bus.a_req || prio_b);
    end

    assign bus.a_gnt = arb_en && a_win;
    assign bus.b_gnt = arb_en && b_win;

    // Idle cycles issue a read of word 0; it is harmless because no rvalid follows it.
    always_comb begin
        bus.ram_wren    = 1'b0;
        bus.ram_address = {AWIDTH{1'b0}};
        bus.ram_data    = {DWIDTH{1'b0}};
`ifdef SPRAM_ARB_INIT_EN
        if (state == ST_INIT) begin
            // Keep the RAM quiet while reset is held so no stray write reaches it.
            bus.ram_wren    = !reset;
            bus.ram_address = init_cnt;
        end else
`endif
        if (bus.a_gnt) begin
            bus.ram_wren    = bus.a_wren;
            bus.ram_address = bus.a_addr;
            bus.ram_data    = bus.a_wdata;
        end else if (bus.b_gnt) begin
            bus.ram_wren    = bus.b_wren;
            bus.ram_address = bus.b_addr;
            bus.ram_data    = bus.b_wdata;
        end
    end

    // The RAM output register feeds both requesters; rvalid tells whose word it is.
    assign bus.a_rdata  = bus.ram_out;
    assign bus.b_rdata  = bus.ram_out;
    assign bus.a_rvalid = rd_valid && !owner_b;
    assign bus.b_rvalid = rd_valid && owner_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_b   <= 1'b0;
            owner_b  <= 1'b0;
            rd_valid <= 1'b0;
`ifdef SPRAM_ARB_INIT_EN
            state    <= ST_INIT;
            init_cnt <= {AWIDTH{1'b0}};
`endif
        end else begin
`ifdef SPRAM_ARB_INIT_EN
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == AWIDTH'(NUM_WORDS - 1))
                    state <= ST_ARB;
            end
`endif
            rd_valid <= (bus.a_gnt && !bus.a_wren) || (bus.b_gnt && !bus.b_wren);
            if (bus.a_gnt || bus.b_gnt) begin
                // Pointer hands priority to whoever was not just served.
                prio_b <= bus.a_gnt;
                if ((bus.a_gnt && !bus.a_wren) || (bus.b_gnt && !bus.b_wren))
                    owner_b <= bus.b_gnt;
            end
        end
    end

endmodule

// File: tb/tb_spram_arbiter_4096_60bit.sv
// tb/tb_spram_arbiter_4096_60bit.sv - randomized bench with reference model for spram_arbiter_4096_60bit
module tb_spram_arbiter_4096_60bit;
    localparam int AW = 12;
    localparam int DW = 60;
    localparam int NW = 4096;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    spram_arbiter_4096_60bit_if bus ();

    spram_arbiter_4096_60bit dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Single-port RAM: registered read, output held on write cycles.
    logic [DW-1:0] ram_mem [NW];
    logic [DW-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (bus.ram_wren) ram_mem[bus.ram_address] = bus.ram_data;
        else              ram_q <= ram_mem[bus.ram_address];
    end
    assign bus.ram_out = ram_q;

    // Reference model state: array contents as seen in grant order, and whose turn it is on a tie.
    logic [DW-1:0] ref_mem [NW];
    bit            turn_b;

    int checks   = 0;
    int failures = 0;

    logic          last_a_gnt, last_b_gnt;
    logic [DW-1:0] last_a_rdata, last_b_rdata;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand60();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // One arbitration cycle: entered at a falling edge with requests driven, leaves at the next one.
    task automatic cycle();
        int            winner;
        logic          w;
        logic [AW-1:0] ad;
        logic [DW-1:0] d;
        bit            rd_exp;
        int            rd_owner;
        logic [DW-1:0] rd_data;
        #1;
        if (bus.a_req && bus.b_req) winner = turn_b ? 2 : 1;
        else if (bus.a_req)         winner = 1;
        else if (bus.b_req)         winner = 2;
        else                        winner = 0;
        check_eq("a_gnt", bus.a_gnt, winner == 1);
        check_eq("b_gnt", bus.b_gnt, winner == 2);
        w = 1'b0; ad = '0; d = '0;
        if (winner == 1) begin w = bus.a_wren; ad = bus.a_addr; d = bus.a_wdata; end
        if (winner == 2) begin w = bus.b_wren; ad = bus.b_addr; d = bus.b_wdata; end
        check_eq("ram_wren", bus.ram_wren, w);
        check_eq("ram_address", bus.ram_address, ad);
        check_eq("ram_data", bus.ram_data, d);
        rd_exp = 0; rd_owner = 0; rd_data = '0;
        if (winner != 0) begin
            turn_b = (winner == 1);
            if (w) ref_mem[ad] = d;
            else begin
                rd_exp = 1; rd_owner = winner; rd_data = ref_mem[ad];
            end
        end
        last_a_gnt = bus.a_gnt;
        last_b_gnt = bus.b_gnt;
        @(posedge clk);
        #1;
        check_eq("a_rvalid", bus.a_rvalid, rd_exp && rd_owner == 1);
        check_eq("b_rvalid", bus.b_rvalid, rd_exp && rd_owner == 2);
        if (rd_exp && rd_owner == 1) check_eq("a_rdata", bus.a_rdata, rd_data);
        if (rd_exp && rd_owner == 2) check_eq("b_rdata", bus.b_rdata, rd_data);
        last_a_rdata = bus.a_rdata;
        last_b_rdata = bus.b_rdata;
        if (winner == 1) bus.a_req = 1'b0;
        if (winner == 2) bus.b_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_a_gnt", bus.a_gnt, 1'b0);
        check_eq("rst_b_gnt", bus.b_gnt, 1'b0);
        check_eq("rst_a_rvalid", bus.a_rvalid, 1'b0);
        check_eq("rst_b_rvalid", bus.b_rvalid, 1'b0);
        check_eq("rst_ram_wren", bus.ram_wren, 1'b0);
        check_eq("rst_ram_address", bus.ram_address, '0);
        check_eq("rst_ram_data", bus.ram_data, '0);
`ifdef SPRAM_ARB_INIT_EN
        check_eq("rst_init_done", bus.init_done, 1'b0);
`else
        check_eq("rst_init_done", bus.init_done, 1'b1);
`endif
        @(negedge clk);
        reset  = 1'b0;
        turn_b = 0;
    endtask

    task automatic set_a(input logic wren, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.a_req = 1'b1; bus.a_wren = wren; bus.a_addr = addr; bus.a_wdata = data;
    endtask

    task automatic set_b(input logic wren, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.b_req = 1'b1; bus.b_wren = wren; bus.b_addr = addr; bus.b_wdata = data;
    endtask

`ifdef SPRAM_ARB_INIT_EN
    // Holds an A request throughout to show nothing is granted while the sweep runs.
    task automatic init_sweep(input int cycles);
        set_a(1'b0, '0, '0);
        for (int i = 0; i < cycles; i++) begin
            #1;
            if (bus.init_done !== 1'b0 || bus.a_gnt !== 1'b0 || bus.ram_wren !== 1'b1 ||
                bus.ram_address !== AW'(i) || bus.ram_data !== '0 || bus.a_rvalid !== 1'b0)
                check_eq("init_sweep", {bus.init_done, bus.a_gnt, bus.ram_wren, bus.a_rvalid,
                                        4'h0, 4'(0), bus.ram_address}, {8'b0010_0000, 8'h00, AW'(i)});
            @(negedge clk);
        end
        bus.a_req = 1'b0;
    endtask
`endif

    initial begin
        logic [DW-1:0] old;
        for (int i = 0; i < NW; i++) begin
            logic [DW-1:0] v;
            v = rand60();
            ram_mem[i] = v;
            ref_mem[i] = v;
        end
        bus.a_req = 1'b0; bus.a_wren = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_wren = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        last_a_gnt = 1'b0; last_b_gnt = 1'b0; last_a_rdata = '0; last_b_rdata = '0;

        do_reset();

`ifdef SPRAM_ARB_INIT_EN
        init_sweep(12'h800);
        check_eq("mid_init_addr", bus.ram_address, 12'h800);
        do_reset();
        init_sweep(NW);
        #1;
        check_eq("init_done_rise", bus.init_done, 1'b1);
        @(negedge clk);
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
`else
        #1;
        check_eq("init_done_tied", bus.init_done, 1'b1);
        @(negedge clk);
`endif

        // Contention from reset: strict alternation, first grant to A.
        for (int i = 0; i < 6; i++) begin
            set_a(1'b0, 12'h010, rand60());
            set_b(1'b0, 12'h020, rand60());
            cycle();
            check_eq("cont_a_gnt", last_a_gnt, (i % 2) == 0);
            check_eq("cont_b_gnt", last_b_gnt, (i % 2) == 1);
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        cycle();

`ifdef SPRAM_ARB_INIT_EN
        set_a(1'b0, 12'h000, '0); cycle(); check_eq("zf_000", last_a_rdata, '0);
        set_a(1'b0, 12'h7FF, '0); cycle(); check_eq("zf_7ff", last_a_rdata, '0);
        set_a(1'b0, 12'hFFF, '0); cycle(); check_eq("zf_fff", last_a_rdata, '0);
`endif

        // Single requester write followed by read of the same word.
        set_a(1'b1, 12'h123, 60'hABC_DEF0_1234_567);
        cycle();
        check_eq("single_wr_gnt", last_a_gnt, 1'b1);
        set_a(1'b0, 12'h123, '0);
        cycle();
        check_eq("single_rd_gnt", last_a_gnt, 1'b1);
        check_eq("single_rd_data", last_a_rdata, 60'hABC_DEF0_1234_567);

        // Hand priority to A, then A read races B write to the same word.
        set_b(1'b0, 12'h000, '0);
        cycle();
        old = ref_mem[12'h040];
        set_a(1'b0, 12'h040, '0);
        set_b(1'b1, 12'h040, 60'h5);
        cycle();
        check_eq("race_a_first", last_a_gnt, 1'b1);
        check_eq("race_old_data", last_a_rdata, old);
        cycle();
        check_eq("race_b_second", last_b_gnt, 1'b1);
        set_a(1'b0, 12'h040, '0);
        cycle();
        check_eq("race_new_data", last_a_rdata, 60'h5);

        // Random traffic; requests stay asserted with a stable command until granted.
        for (int n = 0; n < 600; n++) begin
            if (!bus.a_req && $urandom_range(0, 2) != 0)
                set_a(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15)), rand60());
            if (!bus.b_req && $urandom_range(0, 2) != 0)
                set_b(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15)), rand60());
            cycle();
        end

        // Reset in the middle of traffic clears the pointer and any in-flight rvalid.
        set_a(1'b0, 12'h001, '0);
        #1;
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
